uart_tx_sched: RTL and testbench

//  Round-robin scheduler sharing one UART transmit frame engine among N byte producers.

---
 rtl/uart_tx_sched_pkg.sv | 22 ++
 rtl/uart_tx_sched_if.sv | 29 ++
 rtl/uart_tx_sched_rr_arbiter.sv | 37 +++
 rtl/uart_tx_sched.sv | 158 +++++++++++++++
 tb/tb_uart_tx_sched.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched shared types and helpers.
// FSM state encoding and width helper.
package uart_tx_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEPT = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_GAP    = 3'd4
  } state_t;

  typedef enum logic {
    PAR_EVEN = 1'b0,
    PAR_ODD  = 1'b1
  } par_t;

  function automatic int cw(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// Producer and frame-engine bundle
// for the UART TX scheduler.
interface uart_tx_sched_if #(
  parameter int N_REQ = 4
);

  logic [N_REQ-1:0]   req_valid;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_p_sel;
  logic [N_REQ-1:0]   req_ready;
  logic               tx_start;
  logic [7:0]         tx_data;
  logic               tx_p_sel;
  logic               tx_done;
  logic               baud_tick;

  modport master (
    output req_valid, req_data, req_p_sel,
    output tx_done, baud_tick,
    input  req_ready, tx_start, tx_data, tx_p_sel
  );

  modport slave (
    input  req_valid, req_data, req_p_sel,
    input  tx_done, baud_tick,
    output req_ready, tx_start, tx_data, tx_p_sel
  );

endinterface

// File: rtl/uart_tx_sched_rr_arbiter.sv
// Round-robin pick: first request found
// starting at ptr, wrapping mod N_REQ.
module uart_tx_sched_rr_arbiter
  import uart_tx_sched_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]     req,
  input  logic [cw(N_REQ)-1:0] ptr,
  output logic [N_REQ-1:0]     gnt,
  output logic [cw(N_REQ)-1:0] idx,
  output logic                 any
);

  localparam int IW = cw(N_REQ);

  logic [IW:0] cand;

  // scan from ptr upward, first hit wins
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = {1'b0, ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(N_REQ))
        cand = cand - (IW+1)'(N_REQ);
      if (!any && req[cand[IW-1:0]]) begin
        any                 = 1'b1;
        gnt[cand[IW-1:0]]   = 1'b1;
        idx                 = cand[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler feeding one
// UART TX frame engine from N producers.
module uart_tx_sched
  import uart_tx_sched_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int GAP_TICKS   = 2,
  parameter int TIMEOUT_CYC = 20000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  uart_tx_sched_if.slave       bus,
  output logic                 busy,
  output logic [cw(N_REQ)-1:0] grant_id,
  output logic                 err_timeout
);

  localparam int IW = cw(N_REQ);
  localparam int TW = cw(TIMEOUT_CYC);
  localparam int GW = cw(GAP_TICKS + 1);
  localparam logic [TW-1:0] TO_LOAD =
    TW'(TIMEOUT_CYC - 1);
  localparam logic [GW-1:0] GAP_LOAD =
    GW'(GAP_TICKS);
  localparam logic [IW-1:0] LAST_ID =
    IW'(N_REQ - 1);

  state_t           state, nxt_state;
  logic [IW-1:0]    rr_ptr, nxt_ptr;
  logic [IW-1:0]    gid_q, nxt_gid;
  logic [N_REQ-1:0] gnt_q, nxt_gnt;
  logic [7:0]       data_q, nxt_data;
  logic             psel_q, nxt_psel;
  logic             start_q, nxt_start;
  logic             err_q, nxt_err;
  logic             busy_q, nxt_busy;
  logic [TW-1:0]    to_cnt, nxt_to;
  logic [GW-1:0]    gap_cnt, nxt_gap;

  logic [N_REQ-1:0] arb_gnt;
  logic [IW-1:0]    arb_idx;
  logic             arb_any;

  uart_tx_sched_rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .req (bus.req_valid),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  // state register and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      rr_ptr  <= '0;
      gid_q   <= '0;
      gnt_q   <= '0;
      data_q  <= '0;
      psel_q  <= 1'b0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      to_cnt  <= '0;
      gap_cnt <= '0;
    end else begin
      state   <= nxt_state;
      rr_ptr  <= nxt_ptr;
      gid_q   <= nxt_gid;
      gnt_q   <= nxt_gnt;
      data_q  <= nxt_data;
      psel_q  <= nxt_psel;
      start_q <= nxt_start;
      err_q   <= nxt_err;
      busy_q  <= nxt_busy;
      to_cnt  <= nxt_to;
      gap_cnt <= nxt_gap;
    end
  end

  // next state, counters and capture
  always_comb begin
    nxt_state = state;
    nxt_ptr   = rr_ptr;
    nxt_gid   = gid_q;
    nxt_gnt   = gnt_q;
    nxt_data  = data_q;
    nxt_psel  = psel_q;
    nxt_start = 1'b0;
    nxt_err   = 1'b0;
    nxt_to    = to_cnt;
    nxt_gap   = gap_cnt;
    unique case (state)
      S_IDLE: begin
        if (enable && arb_any) begin
          nxt_state = S_ACCEPT;
          nxt_gid   = arb_idx;
          nxt_gnt   = arb_gnt;
        end
      end
      S_ACCEPT: begin
        if (bus.req_valid[gid_q]) begin
          nxt_data  = bus.req_data[8*gid_q +: 8];
          nxt_psel  = bus.req_p_sel[gid_q];
          nxt_ptr   = (gid_q == LAST_ID) ?
                      '0 : gid_q + 1'b1;
          nxt_start = 1'b1;
          // launch cycle is the first
          // cycle of the timeout window
          nxt_to    = TO_LOAD;
          nxt_state = S_LAUNCH;
        end else begin
          nxt_state = S_IDLE;
        end
      end
      S_LAUNCH: begin
        if (to_cnt != '0)
          nxt_to = to_cnt - 1'b1;
        nxt_state = S_WAIT;
      end
      S_WAIT: begin
        if (bus.tx_done || to_cnt == '0) begin
          nxt_err   = !bus.tx_done;
          nxt_gap   = GAP_LOAD;
          nxt_state = (GAP_TICKS == 0) ?
                      S_IDLE : S_GAP;
        end else begin
          nxt_to = to_cnt - 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt == '0)
          nxt_state = S_IDLE;
        else if (bus.baud_tick)
          nxt_gap = gap_cnt - 1'b1;
      end
      default: nxt_state = S_IDLE;
    endcase
    nxt_busy = (nxt_state != S_IDLE);
  end

  // ready must track valid inside ACCEPT so
  // a withdrawn byte is never consumed
  assign bus.req_ready =
    (state == S_ACCEPT) ?
    (gnt_q & bus.req_valid) : '0;

  assign bus.tx_start = start_q;
  assign bus.tx_data  = data_q;
  assign bus.tx_p_sel = psel_q;
  assign busy         = busy_q;
  assign grant_id     = gid_q;
  assign err_timeout  = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched
// with N=4, GAP_TICKS=2, TIMEOUT_CYC=16.
module tb_uart_tx_sched;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       busy;
  logic [1:0] grant_id;
  logic       err_timeout;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] b [N];

  uart_tx_sched_if #(.N_REQ(N)) bus ();

  uart_tx_sched #(
    .N_REQ       (N),
    .GAP_TICKS   (2),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .bus         (bus),
    .busy        (busy),
    .grant_id    (grant_id),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h",
               tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_byte(
    input int         i,
    input logic [7:0] v
  );
    bus.req_data[8*i +: 8] = v;
  endtask

  task automatic done_pulse();
    bus.tx_done = 1'b1;
    step();
    bus.tx_done = 1'b0;
  endtask

  task automatic wait_ready(input int max);
    int k;
    k = 0;
    bus.baud_tick = 1'b1;
    while (bus.req_ready == '0 && k < max) begin
      step();
      k++;
    end
    bus.baud_tick = 1'b0;
    if (bus.req_ready == '0)
      check("wait_ready", 0, 1);
  endtask

  task automatic wait_idle(input int max);
    int k;
    k = 0;
    bus.baud_tick = 1'b1;
    while (busy && k < max) begin
      step();
      k++;
    end
    bus.baud_tick = 1'b0;
    check("wait_idle", 32'(busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int e;
    logic seen;
    reset         = 1'b1;
    enable        = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_p_sel = '0;
    bus.tx_done   = 1'b0;
    bus.baud_tick = 1'b0;
    repeat (3) step();
    reset = 1'b0;
    check("rst_busy", 32'(busy), 0);
    check("rst_start", 32'(bus.tx_start), 0);
    check("rst_data", 32'(bus.tx_data), 0);
    check("rst_psel", 32'(bus.tx_p_sel), 0);
    check("rst_gid", 32'(grant_id), 0);
    check("rst_err", 32'(err_timeout), 0);
    check("rst_rdy", 32'(bus.req_ready), 0);
    step();
    enable = 1'b1;

    // round-robin, all four valid
    for (int i = 0; i < N; i++) begin
      b[i] = 8'h10 + 8'(i);
      set_byte(i, b[i]);
    end
    bus.req_p_sel = 4'b1010;
    bus.req_valid = 4'b1111;
    for (int f = 0; f < 5; f++) begin
      e = f % N;
      wait_ready(10);
      check("rr_gid", 32'(grant_id), 32'(e));
      check("rr_rdy", 32'(bus.req_ready),
            32'(1 << e));
      step();
      check("rr_start", 32'(bus.tx_start), 1);
      check("rr_data", 32'(bus.tx_data),
            32'(b[e]));
      check("rr_psel", 32'(bus.tx_p_sel),
            32'(e % 2));
      b[e] = b[e] + 8'h40;
      set_byte(e, b[e]);
      if (f == 4) bus.req_valid = '0;
      step();
      step();
      done_pulse();
    end
    wait_idle(20);

    // single request, rr_ptr now 1
    set_byte(2, 8'hA5);
    bus.req_p_sel = 4'b0100;
    bus.req_valid = 4'b0100;
    step();
    check("s_rdy", 32'(bus.req_ready), 32'h4);
    check("s_gid", 32'(grant_id), 2);
    check("s_busy", 32'(busy), 1);
    check("s_nostart", 32'(bus.tx_start), 0);
    step();
    check("s_start", 32'(bus.tx_start), 1);
    check("s_data", 32'(bus.tx_data), 32'hA5);
    check("s_psel", 32'(bus.tx_p_sel), 1);
    check("s_rdy_off", 32'(bus.req_ready), 0);
    bus.req_valid = '0;
    step();
    check("s_start_1cyc", 32'(bus.tx_start), 0);
    step();
    check("s_data_hold", 32'(bus.tx_data), 32'hA5);
    done_pulse();
    check("s_gap_busy", 32'(busy), 1);
    bus.baud_tick = 1'b1;
    step();
    bus.baud_tick = 1'b0;
    step();
    bus.baud_tick = 1'b1;
    step();
    bus.baud_tick = 1'b0;
    check("s_gap_end_busy", 32'(busy), 1);
    step();
    check("s_idle", 32'(busy), 0);

    // timeout, rr_ptr now 3
    set_byte(0, 8'h3C);
    bus.req_p_sel = 4'b0000;
    bus.req_valid = 4'b0001;
    step();
    check("to_gid", 32'(grant_id), 0);
    step();
    check("to_start", 32'(bus.tx_start), 1);
    bus.req_valid = '0;
    seen = 1'b0;
    repeat (15) begin
      step();
      if (err_timeout) seen = 1'b1;
    end
    check("to_early", 32'(seen), 0);
    step();
    check("to_err", 32'(err_timeout), 1);
    step();
    check("to_err_1cyc", 32'(err_timeout), 0);
    check("to_gap_busy", 32'(busy), 1);
    set_byte(1, 8'hC3);
    bus.req_valid = 4'b0010;
    wait_ready(10);
    check("to_next_gid", 32'(grant_id), 1);

    // tx_done on the expiry cycle
    step();
    check("tx_start2", 32'(bus.tx_start), 1);
    check("tx_data2", 32'(bus.tx_data), 32'hC3);
    bus.req_valid = '0;
    repeat (15) step();
    check("ex_no_err_pre", 32'(err_timeout), 0);
    done_pulse();
    check("ex_no_err", 32'(err_timeout), 0);
    check("ex_busy", 32'(busy), 1);
    step();
    check("ex_no_err2", 32'(err_timeout), 0);
    wait_idle(10);

    // enable dropped mid-frame, rr_ptr 2
    set_byte(3, 8'h77);
    bus.req_valid = 4'b1000;
    step();
    check("en_gid", 32'(grant_id), 3);
    step();
    check("en_data", 32'(bus.tx_data), 32'h77);
    bus.req_valid = 4'b0001;
    step();
    enable = 1'b0;
    step();
    step();
    done_pulse();
    seen = 1'b0;
    bus.baud_tick = 1'b1;
    repeat (12) begin
      step();
      if (bus.req_ready != '0) seen = 1'b1;
    end
    bus.baud_tick = 1'b0;
    check("en_no_rdy", 32'(seen), 0);
    check("en_idle", 32'(busy), 0);
    check("en_data_hold", 32'(bus.tx_data),
          32'h77);
    enable = 1'b1;
    wait_ready(5);
    check("en_gid2", 32'(grant_id), 0);
    check("en_rdy2", 32'(bus.req_ready), 1);

    // reset during WAIT_DONE
    step();
    bus.req_valid = '0;
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("mr_busy", 32'(busy), 0);
    check("mr_start", 32'(bus.tx_start), 0);
    check("mr_data", 32'(bus.tx_data), 0);
    check("mr_gid", 32'(grant_id), 0);
    check("mr_err", 32'(err_timeout), 0);
    done_pulse();
    seen = 1'b0;
    repeat (5) begin
      step();
      if (bus.tx_start || busy) seen = 1'b1;
    end
    check("mr_quiet", 32'(seen), 0);
    bus.req_valid = 4'b1011;
    wait_ready(5);
    check("mr_gid0", 32'(grant_id), 0);
    step();
    bus.req_valid = '0;
    step();
    step();
    done_pulse();
    wait_idle(10);

    // valid withdrawn in ACCEPT, rr_ptr 1
    bus.req_valid = 4'b0010;
    step();
    check("vd_gid", 32'(grant_id), 1);
    check("vd_rdy", 32'(bus.req_ready), 32'h2);
    bus.req_valid = '0;
    #1;
    check("vd_rdy_off", 32'(bus.req_ready), 0);
    step();
    check("vd_idle", 32'(busy), 0);
    check("vd_nostart", 32'(bus.tx_start), 0);
    bus.req_valid = 4'b1111;
    wait_ready(5);
    check("vd_ptr_kept", 32'(grant_id), 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
